// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: LC-3b types, opcodes, sequencer states and opcode helpers.
package mem_access_sequencer_pkg;
    typedef logic [15:0] lc3b_word;
    typedef logic [3:0] lc3b_opcode;

    localparam lc3b_opcode OP_LDB = 4'b0010;
    localparam lc3b_opcode OP_STB = 4'b0011;
    localparam lc3b_opcode OP_LDR = 4'b0110;
    localparam lc3b_opcode OP_STR = 4'b0111;
    localparam lc3b_opcode OP_LDI = 4'b1010;
    localparam lc3b_opcode OP_STI = 4'b1011;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;

    typedef enum logic [2:0] {IDLE, PTR_RD, DATA_RD, DATA_WR, DONE} mem_seq_state_t;

    function automatic logic is_load(lc3b_opcode op);
        return op == OP_LDR || op == OP_LDB || op == OP_LDI;
    endfunction

    function automatic logic is_memop(lc3b_opcode op);
        return is_load(op) || op == OP_STR || op == OP_STB || op == OP_STI;
    endfunction

    function automatic logic is_indirect(lc3b_opcode op);
        return op == OP_LDI || op == OP_STI;
    endfunction

    function automatic logic is_byte(lc3b_opcode op);
        return op == OP_LDB || op == OP_STB;
    endfunction
endpackage

// File: rtl/mem_access_sequencer_byte_lane_align.sv
// byte_lane_align: byte-lane mask, store replication and load extraction/sign extension.
module byte_lane_align
    import mem_access_sequencer_pkg::*;
(
    input  logic       addr_lsb_i,
    input  logic       is_byte_i,
    input  lc3b_word   sdata_i,
    input  lc3b_word   rdata_i,
    output logic [1:0] be_o,
    output lc3b_word   wdata_o,
    output lc3b_word   ldata_o
);
    logic [7:0] lane;

    always_comb begin
        lane = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
        be_o = is_byte_i ? (addr_lsb_i ? BE_HI : BE_LO) : BE_WORD;
        wdata_o = is_byte_i ? {2{sdata_i[7:0]}} : sdata_i;
        ldata_o = is_byte_i ? {{8{lane[7]}}, lane} : rdata_i;
    end
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage FSM sequencing LC-3b data-memory accesses, including
// the two-access indirect flow, byte steering and a per-access response watchdog.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr_in,
    input  logic [15:0] store_data,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic        mem_stall,
    output logic [15:0] load_data,
    output logic        load_valid,
    output logic        timeout_err
);
    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    mem_seq_state_t state_q, state_d;
    lc3b_word addr_q, addr_d, data_q, data_d, ptr_q, ptr_d, rdata_q, rdata_d, hold_q;
    lc3b_opcode op_q, op_d;
    logic [15:0] wait_q, wait_d;
    logic timeout_q, timeout_d;
    logic access, expire;
    logic [1:0] al_be;
    lc3b_word al_wdata, al_ldata, base;

    byte_lane_align u_align (
        .addr_lsb_i(addr_q[0]),
        .is_byte_i (is_byte(op_q)),
        .sdata_i   (data_q),
        .rdata_i   (rdata_q),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ldata_o   (al_ldata)
    );

    always_comb begin
        access = state_q == PTR_RD || state_q == DATA_RD || state_q == DATA_WR;
        expire = MAX_WAIT != 0 && wait_q == WAIT_LAST && !dmem_resp;
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        op_d = op_q;
        ptr_d = ptr_q;
        rdata_d = rdata_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (req_valid && is_memop(opcode)) begin
                state_d = is_indirect(opcode) ? PTR_RD : is_load(opcode) ? DATA_RD : DATA_WR;
                addr_d = addr_in;
                data_d = store_data;
                op_d = opcode;
            end
            PTR_RD: if (dmem_resp) begin
                ptr_d = dmem_rdata;
                state_d = op_q == OP_LDI ? DATA_RD : DATA_WR;
            end
            DATA_RD: if (dmem_resp) begin
                rdata_d = dmem_rdata;
                state_d = DONE;
            end
            DATA_WR: if (dmem_resp) state_d = DONE;
            default: state_d = IDLE;
        endcase
        // An abandoned access still retires through DONE so the pipeline is released.
        if (access && expire) begin
            state_d = DONE;
            rdata_d = '0;
            timeout_d = 1'b1;
        end
        wait_d = (access && state_d == state_q) ? wait_q + 16'd1 : '0;
        base = (state_q == PTR_RD || !is_indirect(op_q)) ? addr_q : ptr_q;
        dmem_read = state_q == PTR_RD || state_q == DATA_RD;
        dmem_write = state_q == DATA_WR;
        dmem_address = access ? (base & 16'hFFFE) : '0;
        dmem_byte_enable = dmem_write ? al_be : dmem_read ? BE_WORD : 2'b00;
        dmem_wdata = dmem_write ? al_wdata : '0;
        mem_stall = !reset && (access || (state_q == IDLE && req_valid && is_memop(opcode)));
        load_valid = state_q == DONE && is_load(op_q);
        load_data = load_valid ? al_ldata : hold_q;
        timeout_err = timeout_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            op_q <= '0;
            ptr_q <= '0;
            rdata_q <= '0;
            hold_q <= '0;
            wait_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            op_q <= op_d;
            ptr_q <= ptr_d;
            rdata_q <= rdata_d;
            hold_q <= load_data;
            wait_q <= wait_d;
            timeout_q <= timeout_d;
        end
    end
endmodule
